// File: rtl/snn_spike_rate_decoder.sv
// Rate-coded readout: counts output spikes per neuron over a window of timesteps,
// then scans the counters one per cycle and reports the argmax class and its count.
module snn_spike_rate_decoder #(
    parameter int N_OUTPUTS = 8,
    parameter int COUNT_W   = 8,
    parameter int WINDOW    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_OUTPUTS-1:0]         spikes_in,
    input  logic                         spikes_valid,
    input  logic                         clear,
    output logic                         busy,
    output logic                         result_valid,
    output logic [$clog2(N_OUTPUTS)-1:0] result_class,
    output logic [COUNT_W-1:0]           result_count,
    output logic [1:0]                   dbg_state
);

    localparam int IDX_W = $clog2(N_OUTPUTS);
    localparam int TS_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] cnt_q [N_OUTPUTS];
    logic [COUNT_W-1:0] cnt_d [N_OUTPUTS];
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic [COUNT_W-1:0] best_cnt_q, best_cnt_d;
    logic               busy_q, busy_d;
    logic               result_valid_q, result_valid_d;
    logic [IDX_W-1:0]   result_class_q, result_class_d;
    logic [COUNT_W-1:0] result_count_q, result_count_d;

    logic [COUNT_W-1:0] cand_cnt;
    logic               take_new;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ts_d           = ts_q;
        scan_idx_d     = scan_idx_q;
        best_idx_d     = best_idx_q;
        best_cnt_d     = best_cnt_q;
        busy_d         = busy_q;
        result_valid_d = 1'b0;
        result_class_d = result_class_q;
        result_count_d = result_count_q;
        cand_cnt       = cnt_q[scan_idx_q];
        // Index 0 seeds the running best; later indices must be strictly larger.
        take_new       = (scan_idx_q == '0) || (cand_cnt > best_cnt_q);

        if (clear) begin
            state_d    = ST_ACCUM;
            for (int i = 0; i < N_OUTPUTS; i++) cnt_d[i] = '0;
            ts_d       = '0;
            scan_idx_d = '0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (spikes_valid) begin
                        for (int i = 0; i < N_OUTPUTS; i++) begin
                            if (spikes_in[i] && (cnt_q[i] != CNT_MAX))
                                cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                        if (ts_q == TS_W'(WINDOW - 1)) begin
                            state_d    = ST_SCAN;
                            busy_d     = 1'b1;
                            scan_idx_d = '0;
                        end else begin
                            ts_d = ts_q + 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (take_new) begin
                        best_idx_d = scan_idx_q;
                        best_cnt_d = cand_cnt;
                    end
                    // Last counter: publish the final best directly so the pulse lands in DONE.
                    if (scan_idx_q == IDX_W'(N_OUTPUTS - 1)) begin
                        state_d        = ST_DONE;
                        result_valid_d = 1'b1;
                        result_class_d = take_new ? scan_idx_q : best_idx_q;
                        result_count_d = take_new ? cand_cnt : best_cnt_q;
                    end else begin
                        scan_idx_d = scan_idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d    = ST_ACCUM;
                    for (int i = 0; i < N_OUTPUTS; i++) cnt_d[i] = '0;
                    ts_d       = '0;
                    scan_idx_d = '0;
                    busy_d     = 1'b0;
                end
                default: begin
                    state_d = ST_ACCUM;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_ACCUM;
            for (int i = 0; i < N_OUTPUTS; i++) cnt_q[i] <= '0;
            ts_q           <= '0;
            scan_idx_q     <= '0;
            best_idx_q     <= '0;
            best_cnt_q     <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_class_q <= '0;
            result_count_q <= '0;
        end else begin
            state_q        <= state_d;
            for (int i = 0; i < N_OUTPUTS; i++) cnt_q[i] <= cnt_d[i];
            ts_q           <= ts_d;
            scan_idx_q     <= scan_idx_d;
            best_idx_q     <= best_idx_d;
            best_cnt_q     <= best_cnt_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            result_class_q <= result_class_d;
            result_count_q <= result_count_d;
        end
    end

    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign result_class = result_class_q;
    assign result_count = result_count_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_snn_spike_rate_decoder.sv
// Bench for snn_spike_rate_decoder: directed windows plus random traffic, checked each
// cycle against a window-level reference model; a second instance covers saturation.
module tb_snn_spike_rate_decoder;

    localparam int N     = 8;
    localparam int CW    = 8;
    localparam int WIN   = 16;
    localparam int CMAX  = 255;
    localparam int IW    = 3;

    logic          clk = 1'b0;
    logic          reset, spikes_valid, clear;
    logic [N-1:0]  spikes_in;
    logic          busy, result_valid;
    logic [IW-1:0] result_class;
    logic [CW-1:0] result_count;
    logic [1:0]    dbg_state;

    logic          s_reset, s_valid, s_clear;
    logic [N-1:0]  s_spikes;
    logic          s_busy, s_rv;
    logic [IW-1:0] s_class;
    logic [3:0]    s_count;
    logic [1:0]    s_dbg;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard of directed-window results, in order of expected pulses.
    logic [IW+CW-1:0] exp_q[$];

    // Reference model state (window level).
    int m_cnt [N];
    int m_ts, m_bpos, p_class, p_count, m_class, m_count;
    logic m_busy, m_rv;

    always #5 clk = ~clk;

    snn_spike_rate_decoder #(.N_OUTPUTS(N), .COUNT_W(CW), .WINDOW(WIN)) dut (
        .clk(clk), .reset(reset), .spikes_in(spikes_in), .spikes_valid(spikes_valid),
        .clear(clear), .busy(busy), .result_valid(result_valid),
        .result_class(result_class), .result_count(result_count), .dbg_state(dbg_state)
    );

    snn_spike_rate_decoder #(.N_OUTPUTS(N), .COUNT_W(4), .WINDOW(20)) dut_sat (
        .clk(clk), .reset(s_reset), .spikes_in(s_spikes), .spikes_valid(s_valid),
        .clear(s_clear), .busy(s_busy), .result_valid(s_rv),
        .result_class(s_class), .result_count(s_count), .dbg_state(s_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic sv, input logic [N-1:0] sp,
                              input logic clr);
        m_rv = 1'b0;
        if (rst) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_ts = 0; m_bpos = 0; m_class = 0; m_count = 0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_ts = 0; m_bpos = 0;
        end else if (m_bpos == 0) begin
            if (sv) begin
                for (int i = 0; i < N; i++)
                    if (sp[i] && m_cnt[i] < CMAX) m_cnt[i]++;
                m_ts++;
                if (m_ts == WIN) begin
                    p_class = 0; p_count = m_cnt[0];
                    for (int i = 1; i < N; i++)
                        if (m_cnt[i] > p_count) begin p_class = i; p_count = m_cnt[i]; end
                    for (int i = 0; i < N; i++) m_cnt[i] = 0;
                    m_ts = 0;
                    m_bpos = 1;
                end
            end
        end else begin
            m_bpos++;
            if (m_bpos == N + 1) begin
                m_rv = 1'b1; m_class = p_class; m_count = p_count;
            end else if (m_bpos == N + 2) begin
                m_bpos = 0;
            end
        end
        m_busy = (m_bpos != 0);
    endtask

    task automatic cycle(input logic rst, input logic sv, input logic [N-1:0] sp,
                         input logic clr);
        logic [IW+CW-1:0] e;
        reset = rst; spikes_valid = sv; spikes_in = sp; clear = clr;
        @(posedge clk); #1;
        model_step(rst, sv, sp, clr);
        check("busy", 32'(busy), 32'(m_busy));
        check("result_valid", 32'(result_valid), 32'(m_rv));
        check("result_class", 32'(result_class), m_class);
        check("result_count", 32'(result_count), m_count);
        if (m_rv && result_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("directed_result", 32'({result_class, result_count}), 32'(e));
        end
    endtask

    task automatic beats(input int n, input logic [N-1:0] sp);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, sp, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int lat;
        logic seen;
        reset = 1'b1; spikes_valid = 1'b0; spikes_in = '0; clear = 1'b0;
        s_reset = 1'b1; s_valid = 1'b0; s_spikes = '0; s_clear = 1'b0;

        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 8'hFF, 1'b0);
        idle(2);

        exp_q.push_back({3'd3, 8'd16});
        beats(WIN, 8'h08);
        idle(12);

        exp_q.push_back({3'd2, 8'd16});
        beats(WIN, 8'h24);
        idle(10);

        beats(10, 8'h01);
        cycle(1'b0, 1'b1, 8'h01, 1'b1);
        exp_q.push_back({3'd6, 8'd16});
        beats(WIN, 8'h40);
        idle(10);

        exp_q.push_back({3'd1, 8'd16});
        exp_q.push_back({3'd0, 8'd16});
        beats(WIN, 8'h02);
        beats(N + 1 + WIN, 8'hFF);
        idle(10);

        exp_q.push_back({3'd0, 8'd0});
        beats(WIN, 8'h00);
        idle(10);

        beats(WIN, 8'h08);
        idle(3);
        cycle(1'b1, 1'b0, '0, 1'b0);
        idle(15);

        for (int i = 0; i < 900; i++)
            cycle(1'b0, $urandom_range(0, 3) != 0, N'($urandom),
                  $urandom_range(0, 99) == 0);
        idle(12);

        // Saturating instance: COUNT_W=4, WINDOW=20.
        @(posedge clk); #1;
        s_reset = 1'b0;
        s_valid = 1'b1; s_spikes = 8'h81;
        for (int i = 0; i < 20; i++) begin @(posedge clk); #1; end
        s_valid = 1'b0; s_spikes = '0;
        lat = 0; seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (s_rv) begin seen = 1'b1; lat = k; end
        end
        check("sat_pulse_seen", 32'(seen), 1);
        check("sat_latency", lat, N);
        check("sat_class", 32'(s_class), 0);
        check("sat_count", 32'(s_count), 15);

        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
